// File: rtl/prbs_checker_pkg.sv
// Shared LFSR tap tables, next-bit helper and PRBS checker state type.
// The generator and checker both derive their feedback from lfsr_next_bit.
package lfsr_package;

   localparam int LFSR_MAX_N = 32;
   localparam int IDX_W      = $clog2(LFSR_MAX_N);

   // Number of XNOR taps per width; -1 marks widths with no maximal-length table entry.
   localparam int LFSR_N_TAPS [0:32] = '{
      -1, -1, 2, 2, 2, 2, 2, 2, 4, 2, 2, 2, 4, 4, 4, 2, 4,
      2, 2, 4, 2, 2, 2, 2, 4, 2, 4, 4, 2, 2, 4, 2, 4
   };

   localparam int LFSR_TAPS [0:32][0:3] = '{
      '{0, 0, 0, 0},     '{0, 0, 0, 0},     '{2, 1, 0, 0},     '{3, 2, 0, 0},
      '{4, 3, 0, 0},     '{5, 3, 0, 0},     '{6, 5, 0, 0},     '{7, 6, 0, 0},
      '{8, 6, 5, 4},     '{9, 5, 0, 0},     '{10, 7, 0, 0},    '{11, 9, 0, 0},
      '{12, 6, 4, 1},    '{13, 4, 3, 1},    '{14, 5, 3, 1},    '{15, 14, 0, 0},
      '{16, 15, 13, 4},  '{17, 14, 0, 0},   '{18, 11, 0, 0},   '{19, 6, 2, 1},
      '{20, 17, 0, 0},   '{21, 19, 0, 0},   '{22, 21, 0, 0},   '{23, 18, 0, 0},
      '{24, 23, 22, 17}, '{25, 22, 0, 0},   '{26, 6, 2, 1},    '{27, 5, 2, 1},
      '{28, 25, 0, 0},   '{29, 27, 0, 0},   '{30, 6, 4, 1},    '{31, 28, 0, 0},
      '{32, 22, 2, 1}
   };

   typedef enum logic [1:0] {
      PRBS_SEED,
      PRBS_VERIFY,
      PRBS_LOCKED
   } prbs_chk_state_t;

   // XNOR of the tapped bits: the bit that would be shifted into state[0] next.
   function automatic logic lfsr_next_bit(input int n, input logic [LFSR_MAX_N-1:0] state);
      logic       fb;
      logic [5:0] ni;
      fb = 1'b0;
      ni = 6'(n);
      for (int k = 0; k < 4; k++) begin
         if (k < LFSR_N_TAPS[ni]) begin
            fb = fb ^ state[IDX_W'(LFSR_TAPS[ni][2'(k)] - 1)];
         end
      end
      return ~fb;
   endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Stream-in / status-out bundle between the PRBS checker and its user.
interface prbs_checker_if #(
   parameter int CNT_W = 32
);
   logic             cke;
   logic             bit_in;
   logic             clear;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_count;
   logic [CNT_W-1:0] bit_count;
   logic             sat;

   modport master (
      output cke, bit_in, clear,
      input  locked, err_pulse, err_count, bit_count, sat
   );

   modport slave (
      input  cke, bit_in, clear,
      output locked, err_pulse, err_count, bit_count, sat
   );
endinterface

// File: rtl/prbs_checker_sat_counter.sv
// Saturating up-counter with a sticky flag set when it reaches all-ones.
// Clear wins over a coincident increment and does not need cke.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cke_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         sat_o
);
   logic [W-1:0] cnt_q, cnt_d;
   logic         sat_q, sat_d;

   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr_i) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (cke_i && inc_i && cnt_q != '1) begin
         cnt_d = cnt_q + W'(1);
         if (cnt_d == '1) begin
            sat_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign cnt_o = cnt_q;
   assign sat_o = sat_q;
endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: seeds its shift register from the line, verifies,
// then free-runs a flywheel predictor and counts errors for BER measurement.
module prbs_checker
   import lfsr_package::*;
#(
   parameter int n           = 16,
   parameter int LOCK_CNT    = 32,
   parameter int WIN         = 256,
   parameter int UNLOCK_ERRS = 8,
   parameter int CNT_W       = 32
) (
   input logic           clk,
   input logic           rst,
   prbs_checker_if.slave prbs
);
   localparam int SC_W = $clog2(n + 1);
   localparam int MC_W = $clog2(LOCK_CNT + 1);
   localparam int WB_W = $clog2(WIN + 1);
   localparam int WE_W = $clog2(UNLOCK_ERRS + 1);
   localparam logic [SC_W-1:0] SEED_LAST  = SC_W'(n - 1);
   localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(LOCK_CNT - 1);
   localparam logic [WB_W-1:0] WIN_LAST   = WB_W'(WIN - 1);
   localparam logic [WE_W-1:0] ERRS_LIM   = WE_W'(UNLOCK_ERRS);

   if (n < 2 || n > LFSR_MAX_N) begin : g_bad_width
      $error("prbs_checker: LFSR width n=%0d out of range", n);
   end else if (LFSR_N_TAPS[n] == -1) begin : g_no_taps
      $error("prbs_checker: no tap table entry for n=%0d", n);
   end

   prbs_chk_state_t state_q, state_d;
   logic [n-1:0]    shreg_q, shreg_d;
   logic [SC_W-1:0] seed_cnt_q, seed_cnt_d;
   logic [MC_W-1:0] match_cnt_q, match_cnt_d;
   logic [WB_W-1:0] win_bits_q, win_bits_d;
   logic [WE_W-1:0] win_errs_q, win_errs_d;
   logic            err_pulse_q, err_pulse_d;
   logic [WE_W-1:0] win_errs_inc;
   logic            pred, mismatch, in_locked;
   logic            err_sat, bit_sat;

   assign pred         = lfsr_next_bit(n, LFSR_MAX_N'(shreg_q));
   assign mismatch     = prbs.bit_in != pred;
   assign in_locked    = state_q == PRBS_LOCKED;
   assign win_errs_inc = win_errs_q + WE_W'(mismatch);

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      seed_cnt_d  = seed_cnt_q;
      match_cnt_d = match_cnt_q;
      win_bits_d  = win_bits_q;
      win_errs_d  = win_errs_q;
      err_pulse_d = 1'b0;
      if (prbs.cke) begin
         unique case (state_q)
            PRBS_SEED: begin
               shreg_d = {shreg_q[n-2:0], prbs.bit_in};
               if (seed_cnt_q == SEED_LAST) begin
                  seed_cnt_d = '0;
                  // All-ones is the XNOR lockup state: keep collecting instead.
                  if (shreg_d != '1) begin
                     state_d = PRBS_VERIFY;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + SC_W'(1);
               end
            end
            PRBS_VERIFY: begin
               shreg_d = {shreg_q[n-2:0], prbs.bit_in};
               if (!mismatch) begin
                  if (match_cnt_q == MATCH_LAST) begin
                     match_cnt_d = '0;
                     state_d     = PRBS_LOCKED;
                  end else begin
                     match_cnt_d = match_cnt_q + MC_W'(1);
                  end
               end else begin
                  match_cnt_d = '0;
                  seed_cnt_d  = '0;
                  state_d     = PRBS_SEED;
               end
            end
            PRBS_LOCKED: begin
               // Flywheel on the prediction so one line error is counted once.
               shreg_d     = {shreg_q[n-2:0], pred};
               err_pulse_d = mismatch;
               if (win_errs_inc == ERRS_LIM) begin
                  state_d    = PRBS_SEED;
                  seed_cnt_d = '0;
                  win_bits_d = '0;
                  win_errs_d = '0;
               end else if (win_bits_q == WIN_LAST) begin
                  win_bits_d = '0;
                  win_errs_d = '0;
               end else begin
                  win_bits_d = win_bits_q + WB_W'(1);
                  win_errs_d = win_errs_inc;
               end
            end
            default: state_d = PRBS_SEED;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PRBS_SEED;
         shreg_q     <= '0;
         seed_cnt_q  <= '0;
         match_cnt_q <= '0;
         win_bits_q  <= '0;
         win_errs_q  <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         seed_cnt_q  <= seed_cnt_d;
         match_cnt_q <= match_cnt_d;
         win_bits_q  <= win_bits_d;
         win_errs_q  <= win_errs_d;
         err_pulse_q <= err_pulse_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .cke_i (prbs.cke),
      .clr_i (prbs.clear),
      .inc_i (in_locked && mismatch),
      .cnt_o (prbs.err_count),
      .sat_o (err_sat)
   );

   sat_counter #(.W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .rst   (rst),
      .cke_i (prbs.cke),
      .clr_i (prbs.clear),
      .inc_i (in_locked),
      .cnt_o (prbs.bit_count),
      .sat_o (bit_sat)
   );

   assign prbs.locked    = in_locked;
   assign prbs.err_pulse = err_pulse_q;
   assign prbs.sat       = err_sat | bit_sat;
endmodule

// File: tb/tb_prbs_checker.sv
// Drives a 7-bit XNOR PRBS into two checker configurations and compares every
// cycle against a behavioural model, plus literal checkpoints per scenario.
module tb_prbs_checker;
   localparam int     M_SEED   = 0;
   localparam int     M_VERIFY = 1;
   localparam int     M_LOCKED = 2;
   localparam int     UE   [2] = '{8, 200};
   localparam longint CMAX [2] = '{64'hFFFF_FFFF, 64'd15};

   logic clk = 1'b0;
   logic rst, cke, bit_in, clear;
   always #5 clk = ~clk;

   prbs_checker_if #(.CNT_W(32)) if_a ();
   prbs_checker_if #(.CNT_W(4))  if_b ();
   assign if_a.cke = cke;
   assign if_a.bit_in = bit_in;
   assign if_a.clear = clear;
   assign if_b.cke = cke;
   assign if_b.bit_in = bit_in;
   assign if_b.clear = clear;

   prbs_checker #(.n(7), .LOCK_CNT(32), .WIN(256), .UNLOCK_ERRS(8), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .prbs(if_a)
   );
   prbs_checker #(.n(7), .LOCK_CNT(32), .WIN(256), .UNLOCK_ERRS(200), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .prbs(if_b)
   );

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int         m_mode [2], m_cnt [2], m_match [2], m_wbits [2], m_werrs [2];
   int         m_bits [2], m_lock_idx [2];
   logic [6:0] m_hist [2];
   longint     m_errc [2], m_bitc [2];
   bit         m_sat [2], m_pulse [2];

   task automatic model_step(input int k, input bit r, input bit c, input bit b, input bit cl);
      bit p, e;
      m_pulse[k] = 1'b0;
      if (r) begin
         m_mode[k] = M_SEED; m_cnt[k] = 0; m_match[k] = 0; m_wbits[k] = 0; m_werrs[k] = 0;
         m_bits[k] = 0; m_lock_idx[k] = -1; m_hist[k] = '0;
         m_errc[k] = 0; m_bitc[k] = 0; m_sat[k] = 1'b0;
         return;
      end
      if (c) begin
         m_bits[k]++;
         p = ~(m_hist[k][6] ^ m_hist[k][5]);
         case (m_mode[k])
            M_SEED: begin
               m_hist[k] = {m_hist[k][5:0], b};
               m_cnt[k]++;
               if (m_cnt[k] == 7) begin
                  m_cnt[k] = 0;
                  if (m_hist[k] != 7'h7f) m_mode[k] = M_VERIFY;
               end
            end
            M_VERIFY: begin
               m_hist[k] = {m_hist[k][5:0], b};
               if (b == p) begin
                  m_match[k]++;
                  if (m_match[k] == 32) begin
                     m_match[k] = 0;
                     m_mode[k] = M_LOCKED;
                     if (m_lock_idx[k] < 0) m_lock_idx[k] = m_bits[k];
                  end
               end else begin
                  m_match[k] = 0; m_cnt[k] = 0; m_mode[k] = M_SEED;
               end
            end
            default: begin
               m_hist[k] = {m_hist[k][5:0], p};
               e = (b != p);
               m_pulse[k] = e;
               if (m_bitc[k] < CMAX[k]) m_bitc[k]++;
               if (e && m_errc[k] < CMAX[k]) m_errc[k]++;
               m_wbits[k]++;
               m_werrs[k] += int'(e);
               if (m_werrs[k] == UE[k]) begin
                  m_mode[k] = M_SEED; m_cnt[k] = 0; m_wbits[k] = 0; m_werrs[k] = 0;
               end else if (m_wbits[k] == 256) begin
                  m_wbits[k] = 0; m_werrs[k] = 0;
               end
            end
         endcase
      end
      if (m_errc[k] == CMAX[k] || m_bitc[k] == CMAX[k]) m_sat[k] = 1'b1;
      if (cl) begin
         m_errc[k] = 0; m_bitc[k] = 0; m_sat[k] = 1'b0;
      end
   endtask

   task automatic cmp_dut(input int k, input string nm, input logic lk, input logic ep,
                          input longint ec, input longint bc, input logic st);
      chk({nm, "_locked"}, longint'(lk), longint'(m_mode[k] == M_LOCKED));
      chk({nm, "_err_pulse"}, longint'(ep), longint'(m_pulse[k]));
      chk({nm, "_err_count"}, ec, m_errc[k]);
      chk({nm, "_bit_count"}, bc, m_bitc[k]);
      chk({nm, "_sat"}, longint'(st), longint'(m_sat[k]));
   endtask

   bit s_r, s_c, s_b, s_cl;
   always @(posedge clk) begin
      s_r = rst; s_c = cke; s_b = bit_in; s_cl = clear;
      for (int k = 0; k < 2; k++) model_step(k, s_r, s_c, s_b, s_cl);
      #1;
      if (chk_en) begin
         cmp_dut(0, "a", if_a.locked, if_a.err_pulse, longint'(if_a.err_count),
                 longint'(if_a.bit_count), if_a.sat);
         cmp_dut(1, "b", if_b.locked, if_b.err_pulse, longint'(if_b.err_count),
                 longint'(if_b.bit_count), if_b.sat);
      end
   end

   // ---------------- stimulus ----------------
   logic [6:0] gen;

   function automatic logic gen_step();
      gen = {gen[5:0], ~(gen[6] ^ gen[5])};
      return gen[0];
   endfunction

   task automatic send_bit(input bit inv, input int duty);
      bit done;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         clear = 1'b0;
         if (int'($urandom_range(99)) < duty) begin
            cke = 1'b1;
            bit_in = gen_step() ^ inv;
            done = 1'b1;
         end else begin
            cke = 1'b0;
            bit_in = 1'($urandom_range(1));
         end
      end
   endtask

   task automatic send_n(input int cnt, input int duty);
      for (int i = 0; i < cnt; i++) send_bit(1'b0, duty);
   endtask

   task automatic idle();
      @(negedge clk);
      cke = 1'b0;
      clear = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; cke = 1'b0; clear = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      gen = 7'd2;
   endtask

   initial begin
      rst = 1'b1; cke = 1'b0; bit_in = 1'b0; clear = 1'b0; gen = 7'd2;
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_locked", longint'(if_a.locked), 0);
      chk("rst_err_pulse", longint'(if_a.err_pulse), 0);
      chk("rst_err_count", longint'(if_a.err_count), 0);
      chk("rst_bit_count", longint'(if_a.bit_count), 0);
      chk("rst_sat", longint'(if_a.sat), 0);
      rst = 1'b0;

      // 1: clean stream, lock after bit 39
      send_n(38, 100); idle();
      chk("s1_not_locked_38", longint'(if_a.locked), 0);
      send_n(1, 100); idle();
      chk("s1_locked_39", longint'(if_a.locked), 1);
      chk("s1_model_lock_idx", m_lock_idx[0], 39);
      send_n(961, 100); idle();
      chk("s1_err_count", longint'(if_a.err_count), 0);
      chk("s1_bit_count", longint'(if_a.bit_count), 961);
      $display("scenario 1: clean 1000 bits, err=%0d bits=%0d", if_a.err_count, if_a.bit_count);

      // 2: single inverted bit
      send_bit(1'b1, 100); idle();
      chk("s2_err_pulse", longint'(if_a.err_pulse), 1);
      chk("s2_err_count", longint'(if_a.err_count), 1);
      chk("s2_locked", longint'(if_a.locked), 1);
      send_n(100, 100); idle();
      chk("s2_err_count_after", longint'(if_a.err_count), 1);
      chk("s2_bit_count_after", longint'(if_a.bit_count), 1062);
      $display("scenario 2: one inverted bit, err=%0d", if_a.err_count);

      // 3: clear, then 8 consecutive errors force unlock, then relock
      @(negedge clk); clear = 1'b1; cke = 1'b0;
      idle();
      chk("s3_clear_err", longint'(if_a.err_count), 0);
      chk("s3_clear_bits", longint'(if_a.bit_count), 0);
      for (int i = 0; i < 7; i++) send_bit(1'b1, 100);
      idle();
      chk("s3_locked_after_7", longint'(if_a.locked), 1);
      chk("s3_err_after_7", longint'(if_a.err_count), 7);
      send_bit(1'b1, 100); idle();
      chk("s3_err_after_8", longint'(if_a.err_count), 8);
      chk("s3_unlocked", longint'(if_a.locked), 0);
      send_n(38, 100); idle();
      chk("s3_not_relocked_38", longint'(if_a.locked), 0);
      send_n(1, 100); idle();
      chk("s3_relocked_39", longint'(if_a.locked), 1);
      $display("scenario 3: burst of 8, err=%0d relocked=%0d", if_a.err_count, if_a.locked);

      // 4: all-ones line never leaves SEED
      do_reset();
      for (int i = 0; i < 500; i++) begin
         @(negedge clk); cke = 1'b1; bit_in = 1'b1;
      end
      idle();
      chk("s4_locked", longint'(if_a.locked), 0);
      chk("s4_err_count", longint'(if_a.err_count), 0);
      chk("s4_bit_count", longint'(if_a.bit_count), 0);
      $display("scenario 4: all-ones, locked=%0d", if_a.locked);

      // 5: 30% cke duty, same bit-indexed behaviour; clear beats a coincident bit
      do_reset();
      send_n(38, 30); idle();
      chk("s5_not_locked_38", longint'(if_a.locked), 0);
      send_n(1, 30); idle();
      chk("s5_locked_39", longint'(if_a.locked), 1);
      send_n(961, 30); idle();
      chk("s5_model_lock_idx", m_lock_idx[0], 39);
      chk("s5_err_count", longint'(if_a.err_count), 0);
      chk("s5_bit_count", longint'(if_a.bit_count), 961);
      @(negedge clk); clear = 1'b1; cke = 1'b1; bit_in = gen_step();
      idle();
      chk("s5_clear_err", longint'(if_a.err_count), 0);
      chk("s5_clear_bits", longint'(if_a.bit_count), 0);
      $display("scenario 5: 30%% duty, lock idx=%0d", m_lock_idx[0]);

      // 6: 4-bit counters saturate; reset while locked
      do_reset();
      send_n(39, 100); idle();
      chk("s6_locked", longint'(if_b.locked), 1);
      for (int i = 0; i < 200; i++) send_bit(i % 3 == 2, 100);
      idle();
      chk("s6_err_count_sat", longint'(if_b.err_count), 15);
      chk("s6_sat", longint'(if_b.sat), 1);
      chk("s6_still_locked", longint'(if_b.locked), 1);
      @(negedge clk); rst = 1'b1; cke = 1'b1; bit_in = gen_step();
      @(negedge clk);
      chk("s6_rst_locked", longint'(if_b.locked), 0);
      chk("s6_rst_err_count", longint'(if_b.err_count), 0);
      chk("s6_rst_bit_count", longint'(if_b.bit_count), 0);
      chk("s6_rst_sat", longint'(if_b.sat), 0);
      chk("s6_rst_err_pulse", longint'(if_b.err_pulse), 0);
      rst = 1'b0; cke = 1'b0;
      $display("scenario 6: saturation and mid-lock reset done");
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
